haz_detect_unit: RTL and testbench



---
 rtl/haz_pkg.sv | 31 +++
 rtl/haz_bht.sv | 40 ++++
 rtl/haz_detect_unit.sv | 110 +++++++++++
 tb/tb_haz_detect_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/haz_pkg.sv
// Shared types and constants for the hazard-detection slice: shadow-slot entry,
// BHT counter encoding and the saturating counter step.
package haz_pkg;

  // Slots carry register indices at this width; narrower ports are zero-extended.
  localparam int unsigned RD_W = 8;

  localparam logic [1:0] BHT_INIT = 2'b01;
  localparam logic [1:0] CNT_MIN  = 2'b00;
  localparam logic [1:0] CNT_MAX  = 2'b11;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            wr;
    logic            load;
    logic            mem;
    logic            branch;
    logic            pred;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) begin
      return (cnt == CNT_MAX) ? cnt : cnt + 2'd1;
    end
    return (cnt == CNT_MIN) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/haz_bht.sv
// Branch history table of 2-bit saturating counters; combinational read, update at the edge.
// A same-index read and update in one cycle returns the old counter.
module haz_bht #(
  parameter int unsigned BHT_IDX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BHT_IDX-1:0] rd_idx,
  output logic               rd_taken,
  input  logic               upd_vld,
  input  logic [BHT_IDX-1:0] upd_idx,
  input  logic               upd_taken
);
  import haz_pkg::*;

  localparam int unsigned N_CNT = 1 << BHT_IDX;

  logic [1:0] cnt_q [N_CNT];
  logic [1:0] cnt_d [N_CNT];

  always_comb begin
    cnt_d = cnt_q;
    if (upd_vld) begin
      cnt_d[upd_idx] = sat_step(cnt_q[upd_idx], upd_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CNT; i++) begin
        cnt_q[i] <= BHT_INIT;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_taken = cnt_q[rd_idx][1];

endmodule

// File: rtl/haz_detect_unit.sv
// Hazard detection ahead of the resolver: shadow EX/MEM/WB slots plus a 2-bit BHT.
// Flags are combinational from slot state and ID fields; stall/flush only steer the slot advance.
module haz_detect_unit #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned BHT_IDX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_wr,
  input  logic               id_load,
  input  logic               id_mem,
  input  logic               id_branch,
  input  logic [BHT_IDX-1:0] id_pc_idx,
  input  logic               ex_br_taken,
  input  logic               stall_in,
  input  logic               flush_in,
  output logic               haz_data,
  output logic               fwd_ok,
  output logic               haz_str,
  output logic               haz_ctrl,
  output logic               br_crct,
  output logic               pred_taken
);
  import haz_pkg::*;

  slot_t              ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [BHT_IDX-1:0] ex_idx_q, ex_idx_d;
  logic [RD_W-1:0]    rs1_x, rs2_x;
  logic               ex_hit, mem_hit, wb_hit;
  logic               bht_pred;
  logic               unused_wb;

  // r0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic slot_hit(input slot_t s, input logic [RD_W-1:0] r1, input logic [RD_W-1:0] r2,
                                    input logic u1, input logic u2);
    logic live;
    live = s.valid && s.wr && (s.rd != '0);
    return live && ((u1 && (r1 == s.rd)) || (u2 && (r2 == s.rd)));
  endfunction

  assign rs1_x = RD_W'(id_rs1);
  assign rs2_x = RD_W'(id_rs2);

  always_comb begin
    ex_d        = SLOT_BUBBLE;
    ex_d.valid  = id_valid;
    ex_d.rd     = RD_W'(id_rd);
    ex_d.wr     = id_wr;
    ex_d.load   = id_load;
    ex_d.mem    = id_mem;
    ex_d.branch = id_branch;
    ex_d.pred   = bht_pred;
    ex_idx_d    = id_pc_idx;
    mem_d       = ex_q;
    wb_d        = mem_q;
    // A flush squashes the wrong-path instruction currently in EX as well as the ID one.
    if (flush_in) begin
      ex_d  = SLOT_BUBBLE;
      mem_d = SLOT_BUBBLE;
    end else if (stall_in) begin
      ex_d = SLOT_BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= SLOT_BUBBLE;
      mem_q    <= SLOT_BUBBLE;
      wb_q     <= SLOT_BUBBLE;
      ex_idx_q <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      ex_idx_q <= ex_idx_d;
    end
  end

  assign ex_hit  = id_valid && slot_hit(ex_q,  rs1_x, rs2_x, id_rs1_used, id_rs2_used);
  assign mem_hit = id_valid && slot_hit(mem_q, rs1_x, rs2_x, id_rs1_used, id_rs2_used);
  assign wb_hit  = id_valid && slot_hit(wb_q,  rs1_x, rs2_x, id_rs1_used, id_rs2_used);

  assign haz_data   = ex_hit || mem_hit || wb_hit;
  assign fwd_ok     = !(ex_hit && ex_q.load);
  assign haz_str    = id_valid && mem_q.valid && mem_q.mem;
  assign haz_ctrl   = ex_q.valid && ex_q.branch;
  assign br_crct    = !(haz_ctrl && (ex_br_taken != ex_q.pred));
  assign pred_taken = bht_pred;

  assign unused_wb = ^{wb_q.load, wb_q.mem, wb_q.branch, wb_q.pred};

  haz_bht #(
    .BHT_IDX(BHT_IDX)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (id_pc_idx),
    .rd_taken (bht_pred),
    .upd_vld  (haz_ctrl),
    .upd_idx  (ex_idx_q),
    .upd_taken(ex_br_taken)
  );

endmodule

// File: tb/tb_haz_detect_unit.sv
// Directed bench for haz_detect_unit: one table row per cycle, expected flags hand-derived,
// plus hand-written reset sequences.
module tb_haz_detect_unit;

  typedef struct {
    string       nm;
    logic        vld;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic        mem;
    logic        br;
    logic [3:0]  idx;
    logic        tk;
    logic        st;
    logic        fl;
    logic [5:0]  exp;   // {haz_data, fwd_ok, haz_str, haz_ctrl, br_crct, pred_taken}
  } vec_t;

  localparam int NVEC = 41;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_wr, id_load, id_mem, id_branch;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_pc_idx;
  logic       ex_br_taken, stall_in, flush_in;
  logic       haz_data, fwd_ok, haz_str, haz_ctrl, br_crct, pred_taken;

  int   checks = 0;
  int   failures = 0;
  vec_t tbl [NVEC];

  always #5 clk = ~clk;

  haz_detect_unit #(
    .REG_AW (5),
    .BHT_IDX(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .id_rd      (id_rd),
    .id_wr      (id_wr),
    .id_load    (id_load),
    .id_mem     (id_mem),
    .id_branch  (id_branch),
    .id_pc_idx  (id_pc_idx),
    .ex_br_taken(ex_br_taken),
    .stall_in   (stall_in),
    .flush_in   (flush_in),
    .haz_data   (haz_data),
    .fwd_ok     (fwd_ok),
    .haz_str    (haz_str),
    .haz_ctrl   (haz_ctrl),
    .br_crct    (br_crct),
    .pred_taken (pred_taken)
  );

  function automatic vec_t mk(input string nm, input int vld, input int rs1, input int u1,
                              input int rs2, input int u2, input int rd, input int wr,
                              input int ld, input int mem, input int br, input int idx,
                              input int tk, input int st, input int fl, input int e);
    vec_t v;
    v.nm  = nm;
    v.vld = 1'(vld);  v.rs1 = 5'(rs1); v.u1  = 1'(u1);  v.rs2 = 5'(rs2); v.u2 = 1'(u2);
    v.rd  = 5'(rd);   v.wr  = 1'(wr);  v.ld  = 1'(ld);  v.mem = 1'(mem); v.br = 1'(br);
    v.idx = 4'(idx);  v.tk  = 1'(tk);  v.st  = 1'(st);  v.fl  = 1'(fl);  v.exp = 6'(e);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_valid    = v.vld;
    id_rs1      = v.rs1;
    id_rs1_used = v.u1;
    id_rs2      = v.rs2;
    id_rs2_used = v.u2;
    id_rd       = v.rd;
    id_wr       = v.wr;
    id_load     = v.ld;
    id_mem      = v.mem;
    id_branch   = v.br;
    id_pc_idx   = v.idx;
    ex_br_taken = v.tk;
    stall_in    = v.st;
    flush_in    = v.fl;
  endtask

  task automatic chk6(input string nm, input logic [5:0] e);
    logic [5:0] a;
    a = {haz_data, fwd_ok, haz_str, haz_ctrl, br_crct, pred_taken};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: {data,fwd,str,ctrl,crct,pred} got %b required %b", nm, a, e);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %b required %b", nm, a, e);
    end
  endtask

  initial begin
    //                  nm               vld rs1 u1 rs2 u2 rd wr ld mem br idx tk st fl  exp
    tbl[0]  = mk("idle",            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[1]  = mk("add_rd3",         1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[2]  = mk("sub_rs1_3",       1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 'b110010);
    tbl[3]  = mk("bubble",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[4]  = mk("load_rd3",        1, 0, 0, 0, 0, 3, 1, 1, 1, 0, 0, 0, 0, 0, 'b010010);
    tbl[5]  = mk("load_use_rs2",    1, 0, 0, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 'b100010);
    tbl[6]  = mk("mem_port_conf",   1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b011010);
    tbl[7]  = mk("wb_hit_str_clr",  1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b110010);
    tbl[8]  = mk("wb_cleared",      1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[9]  = mk("load_rd6",        1, 0, 0, 0, 0, 6, 1, 1, 1, 0, 0, 0, 0, 0, 'b010010);
    tbl[10] = mk("alu_rd6",         1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[11] = mk("ex_alu_over_ld",  1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b111010);
    tbl[12] = mk("write_r0",        1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[13] = mk("read_r0",         1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[14] = mk("write_rd7",       1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[15] = mk("unused_src_fl",   1, 7, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'b010010);
    tbl[16] = mk("post_flush_rs7",  1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[17] = mk("stall_wr_rd8",    1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 'b010010);
    tbl[18] = mk("post_stall_rs8",  1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[19] = mk("write_rd9",       1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[20] = mk("flush_and_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'b010010);
    tbl[21] = mk("post_flst_rs9",   1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[22] = mk("write_rd10",      1, 0, 0, 0, 0,10, 1, 0, 0, 0, 0, 0, 0, 0, 'b010010);
    tbl[23] = mk("stall_only",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'b010010);
    tbl[24] = mk("stall_keeps_mem", 1,10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b110010);
    tbl[25] = mk("br_idx5",         1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 'b010010);
    tbl[26] = mk("br_mispred",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 'b010100);
    tbl[27] = mk("bht_now_taken",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 'b010011);
    tbl[28] = mk("bht_idx6_same",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 'b010010);
    tbl[29] = mk("br_idx5_b",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 'b010011);
    tbl[30] = mk("br_correct",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 'b010111);
    tbl[31] = mk("br_idx5_c",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 'b010011);
    tbl[32] = mk("br_nt_mispred",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 'b010101);
    tbl[33] = mk("bht_after_dec",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 'b010011);
    tbl[34] = mk("br_idx5_d",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 'b010011);
    tbl[35] = mk("br_taken_to_11",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 'b010111);
    tbl[36] = mk("br_idx5_e",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 'b010011);
    tbl[37] = mk("br_taken_sat",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 'b010111);
    tbl[38] = mk("bht_stays_11",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 'b010011);
    tbl[39] = mk("br_nt_from_11",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 'b010101);
    tbl[40] = mk("bht_back_to_10",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 'b010011);

    rst = 1'b1;
    drive(tbl[0]);
    #1;
    chk6("reset_outputs", 6'b010010);
    for (int i = 0; i < 16; i++) begin
      id_pc_idx = 4'(i);
      #1;
      chk1($sformatf("reset_pred_idx%0d", i), pred_taken, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      chk6(tbl[i].nm, tbl[i].exp);
    end

    // Reset mid-stream: build up a hazard and an EX branch, then reset between edges.
    @(negedge clk);
    drive(mk("wr3_br", 1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 5, 0, 0, 0, 0));
    #2;
    chk6("pre_rst_writer", 6'b010011);
    @(negedge clk);
    drive(mk("rd3", 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0));
    #2;
    chk6("pre_rst_hazard", 6'b110101);
    #1;
    rst = 1'b1;
    #1;
    chk6("async_rst_no_edge", 6'b010010);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk6("post_rst_state_gone", 6'b010010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
